// File: rtl/q2a03_oam_dma.sv
// Sprite (OAM) DMA engine: snoops CPU writes to the DMA page register, halts the CPU and copies one 256-byte page to the OAM data port.
// Optional Q2A03_DMA_ALIGN_EN inserts an ALIGN cycle so the first READ lands on an even ("get") M-cycle.
module q2a03_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rdwr,
    input  logic [7:0]  bus_rd_data,
    output logic        G_ready,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wr_data,
    output logic        bus_rdwr,
    output logic        dma_active
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    logic [2:0] state;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] data_latch;
    logic       phy2_d;
    logic       fall;
    logic       trigger;
    logic       align_needed;

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            phy2_d <= 1'b0;
        end else begin
            phy2_d <= G_phy2;
        end
    end

    // One-clock strobe marking the end of every CPU M-cycle.
    assign fall    = phy2_d & ~G_phy2;
    assign trigger = (state == ST_IDLE) && !cpu_rdwr && (cpu_addr == DMA_REG_ADDR);

`ifdef Q2A03_DMA_ALIGN_EN
    logic parity;

    // Free-running from reset so it tracks get/put cycles even while idle.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            parity <= 1'b0;
        end else if (fall) begin
            parity <= ~parity;
        end
    end

    assign align_needed = parity;
`else
    assign align_needed = 1'b0;
`endif

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state      <= ST_IDLE;
            page       <= 8'h00;
            index      <= 8'h00;
            data_latch <= 8'h00;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        page  <= cpu_wr_data;
                        index <= 8'h00;
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    state <= align_needed ? ST_ALIGN : ST_READ;
                end
                ST_ALIGN: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    data_latch <= bus_rd_data;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Index wraps to zero on the last byte, leaving it ready for the next transfer.
                    index <= index + 8'd1;
                    state <= (index == 8'hFF) ? ST_IDLE : ST_READ;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        G_ready     = 1'b1;
        dma_active  = 1'b0;
        bus_addr    = cpu_addr;
        bus_wr_data = cpu_wr_data;
        bus_rdwr    = cpu_rdwr;
        case (state)
            ST_IDLE: begin
            end
            ST_READ: begin
                G_ready     = 1'b0;
                dma_active  = 1'b1;
                bus_addr    = {page, index};
                bus_rdwr    = 1'b1;
                bus_wr_data = 8'hFF;
            end
            ST_WRITE: begin
                G_ready     = 1'b0;
                dma_active  = 1'b1;
                bus_addr    = OAM_DATA_ADDR;
                bus_rdwr    = 1'b0;
                bus_wr_data = data_latch;
            end
            default: begin
                // HALT and ALIGN: dummy read at the stalled CPU address, CPU writes suppressed.
                G_ready     = 1'b0;
                dma_active  = 1'b1;
                bus_addr    = cpu_addr;
                bus_rdwr    = 1'b1;
                bus_wr_data = 8'hFF;
            end
        endcase
    end

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Directed bench for q2a03_oam_dma: bus/RAM model sampled at each M-cycle end, OAM write scoreboard.
// Expectations follow Q2A03_DMA_ALIGN_EN when it is defined for the build.
module tb_q2a03_oam_dma;

`ifdef Q2A03_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        G_clock;
    logic        G_reset;
    logic        G_phy2;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rdwr;
    logic [7:0]  bus_rd_data;
    logic        G_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_rdwr;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [15:0] log_addr[$];
    logic        log_rdwr[$];
    logic [7:0]  log_data[$];
    logic [7:0]  oam_log[$];
    logic [7:0]  exp_q[$];
    int          ready_low_cnt;
    int          fall_cnt;
    int          pass_cnt;
    int          total_cnt;

    q2a03_oam_dma dut (
        .G_clock     (G_clock),
        .G_reset     (G_reset),
        .G_phy2      (G_phy2),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rdwr    (cpu_rdwr),
        .bus_rd_data (bus_rd_data),
        .G_ready     (G_ready),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rdwr    (bus_rdwr),
        .dma_active  (dma_active)
    );

    // Clock / phase generation: one M-cycle is four G_clock periods.
    initial begin
        G_clock = 1'b0;
        forever #5 G_clock = ~G_clock;
    end

    initial begin
        G_phy2 = 1'b0;
        #10;
        forever begin
            G_phy2 = 1'b1;
            #20;
            G_phy2 = 1'b0;
            #20;
        end
    end

    assign bus_rd_data = mem[bus_addr];

    // Bus model: samples each M-cycle just before the DUT acts on its end.
    always @(negedge G_phy2) begin
        if (!G_reset) begin
            fall_cnt = 0;
        end else begin
            if (!G_ready) ready_low_cnt++;
            if (dma_active) begin
                log_addr.push_back(bus_addr);
                log_rdwr.push_back(bus_rdwr);
                log_data.push_back(bus_wr_data);
            end
            if (!bus_rdwr) begin
                if (bus_addr == 16'h2004) oam_log.push_back(bus_wr_data);
                else mem[bus_addr] = bus_wr_data;
            end
            fall_cnt++;
        end
    end

    task automatic wait_mcycle();
        @(negedge G_phy2);
        @(posedge G_clock);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr    = 16'h8000;
        cpu_rdwr    = 1'b1;
        cpu_wr_data = 8'h00;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_rdwr.delete();
        log_data.delete();
        oam_log.delete();
        exp_q.delete();
        ready_low_cnt = 0;
    endtask

    task automatic test_reset();
        G_reset = 1'b0;
        cpu_addr    = 16'h1234;
        cpu_wr_data = 8'hA5;
        cpu_rdwr    = 1'b0;
        repeat (3) @(posedge G_clock);
        #1;
        total_cnt++;
        if (G_ready !== 1'b1 || dma_active !== 1'b0) $display("FAIL reset_ctrl: ready=%b active=%b, want 1/0", G_ready, dma_active);
        else pass_cnt++;
        total_cnt++;
        if (bus_addr !== 16'h1234 || bus_wr_data !== 8'hA5 || bus_rdwr !== 1'b0)
            $display("FAIL reset_bus: addr=%h data=%h rdwr=%b, want 1234/a5/0", bus_addr, bus_wr_data, bus_rdwr);
        else pass_cnt++;
        cpu_idle();
        @(posedge G_clock);
        #1 G_reset = 1'b1;
    endtask

    // Triggers a DMA from 'page' so the HALT-ending fall has parity 'halt_odd', then checks the whole transfer.
    task automatic do_transfer(input string name, input logic [7:0] page, input bit halt_odd, input bit force_wr);
        int exp_len;
        int off;
        int bad_rd;
        int bad_wr;
        logic [7:0] iv;
        logic [15:0] src;
        clear_logs();
        wait_mcycle();
        if (((fall_cnt + 1) % 2) != int'(halt_odd)) wait_mcycle();
        exp_len = (ALIGN_EN && halt_odd) ? 514 : 513;
        cpu_addr    = 16'h4014;
        cpu_wr_data = page;
        cpu_rdwr    = 1'b0;
        wait_mcycle();
        cpu_idle();
        total_cnt++;
        if (G_ready !== 1'b0 || dma_active !== 1'b1) $display("FAIL %s_start: ready=%b active=%b, want 0/1", name, G_ready, dma_active);
        else pass_cnt++;
        if (force_wr) begin
            repeat (10) wait_mcycle();
            cpu_addr    = 16'h4014;
            cpu_wr_data = 8'h07;
            cpu_rdwr    = 1'b0;
            repeat (3) wait_mcycle();
            cpu_idle();
        end
        repeat (600) wait_mcycle();
        total_cnt++;
        if (G_ready !== 1'b1 || dma_active !== 1'b0) $display("FAIL %s_done: ready=%b active=%b, want 1/0", name, G_ready, dma_active);
        else pass_cnt++;
        total_cnt++;
        if (ready_low_cnt != exp_len) $display("FAIL %s_len: ready low %0d cycles, want %0d", name, ready_low_cnt, exp_len);
        else pass_cnt++;
        total_cnt++;
        if (log_addr.size() != exp_len) $display("FAIL %s_log: %0d dma cycles, want %0d", name, log_addr.size(), exp_len);
        else pass_cnt++;
        if (log_addr.size() == exp_len) begin
            off = exp_len - 512;
            total_cnt++;
            if (log_addr[0] !== 16'h8000 || log_rdwr[0] !== 1'b1) $display("FAIL %s_halt: addr=%h rdwr=%b, want 8000/1", name, log_addr[0], log_rdwr[0]);
            else pass_cnt++;
            total_cnt++;
            if (log_addr[off] !== {page, 8'h00} || log_rdwr[off] !== 1'b1)
                $display("FAIL %s_first_read: addr=%h rdwr=%b, want %h00/1", name, log_addr[off], log_rdwr[off], page);
            else pass_cnt++;
            bad_rd = -1;
            bad_wr = -1;
            for (int i = 0; i < 256; i++) begin
                iv  = i[7:0];
                src = {page, iv};
                if (bad_rd < 0 && (log_addr[off + 2 * i] !== src || log_rdwr[off + 2 * i] !== 1'b1)) bad_rd = i;
                if (bad_wr < 0 && (log_addr[off + 2 * i + 1] !== 16'h2004 || log_rdwr[off + 2 * i + 1] !== 1'b0 ||
                                   log_data[off + 2 * i + 1] !== mem[src])) bad_wr = i;
            end
            total_cnt++;
            if (bad_rd >= 0) $display("FAIL %s_reads: byte %0d addr=%h, want %h", name, bad_rd, log_addr[off + 2 * bad_rd], {page, bad_rd[7:0]});
            else pass_cnt++;
            total_cnt++;
            if (bad_wr >= 0) $display("FAIL %s_writes: byte %0d addr=%h data=%h", name, bad_wr, log_addr[off + 2 * bad_wr + 1], log_data[off + 2 * bad_wr + 1]);
            else pass_cnt++;
        end
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            exp_q.push_back(mem[{page, iv}]);
        end
        total_cnt++;
        if (oam_log.size() != 256) $display("FAIL %s_oam_count: %0d writes, want 256", name, oam_log.size());
        else pass_cnt++;
        bad_wr = 0;
        while (exp_q.size() > 0 && oam_log.size() > 0) begin
            if (oam_log.pop_front() !== exp_q.pop_front()) bad_wr++;
        end
        total_cnt++;
        if (bad_wr != 0) $display("FAIL %s_oam_data: %0d bytes differ, want 0", name, bad_wr);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_transfer("basic", 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_align_parity();
        do_transfer("even", 8'h02, 1'b0, 1'b0);
        do_transfer("odd", 8'h02, 1'b1, 1'b0);
    endtask

    task automatic test_page_ff();
        do_transfer("page_ff", 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_forced_write();
        do_transfer("forced", 8'h02, 1'b1, 1'b1);
    endtask

    task automatic test_passthrough();
        wait_mcycle();
        ready_low_cnt = 0;
        cpu_addr = 16'h4014;
        cpu_rdwr = 1'b1;
        #1;
        total_cnt++;
        if (bus_addr !== 16'h4014 || bus_rdwr !== 1'b1) $display("FAIL pass_read: addr=%h rdwr=%b, want 4014/1", bus_addr, bus_rdwr);
        else pass_cnt++;
        wait_mcycle();
        cpu_addr    = 16'h4015;
        cpu_wr_data = 8'h33;
        cpu_rdwr    = 1'b0;
        #1;
        total_cnt++;
        if (bus_addr !== 16'h4015 || bus_wr_data !== 8'h33 || bus_rdwr !== 1'b0)
            $display("FAIL pass_write: addr=%h data=%h rdwr=%b, want 4015/33/0", bus_addr, bus_wr_data, bus_rdwr);
        else pass_cnt++;
        wait_mcycle();
        cpu_idle();
        repeat (4) wait_mcycle();
        total_cnt++;
        if (ready_low_cnt != 0 || dma_active !== 1'b0) $display("FAIL pass_no_trigger: low=%0d active=%b, want 0/0", ready_low_cnt, dma_active);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        clear_logs();
        wait_mcycle();
        cpu_addr    = 16'h4014;
        cpu_wr_data = 8'h02;
        cpu_rdwr    = 1'b0;
        wait_mcycle();
        cpu_idle();
        repeat (100) wait_mcycle();
        #10 G_reset = 1'b0;
        #1;
        total_cnt++;
        if (G_ready !== 1'b1 || dma_active !== 1'b0) $display("FAIL abort_ctrl: ready=%b active=%b, want 1/0", G_ready, dma_active);
        else pass_cnt++;
        total_cnt++;
        if (bus_addr !== 16'h8000 || bus_rdwr !== 1'b1) $display("FAIL abort_bus: addr=%h rdwr=%b, want 8000/1", bus_addr, bus_rdwr);
        else pass_cnt++;
        total_cnt++;
        if (oam_log.size() != 49) $display("FAIL abort_partial: %0d writes, want 49", oam_log.size());
        else pass_cnt++;
        if (oam_log.size() == 49) begin
            total_cnt++;
            if (oam_log[48] !== 8'h6A) $display("FAIL abort_last: data=%h, want 6a", oam_log[48]);
            else pass_cnt++;
        end
        repeat (3) wait_mcycle();
        G_reset = 1'b1;
        wait_mcycle();
        ready_low_cnt = 0;
        cpu_addr    = 16'h4000;
        cpu_wr_data = 8'h11;
        cpu_rdwr    = 1'b0;
        #1;
        total_cnt++;
        if (bus_addr !== 16'h4000 || bus_wr_data !== 8'h11 || bus_rdwr !== 1'b0)
            $display("FAIL post_reset_write: addr=%h data=%h rdwr=%b, want 4000/11/0", bus_addr, bus_wr_data, bus_rdwr);
        else pass_cnt++;
        wait_mcycle();
        cpu_idle();
        repeat (4) wait_mcycle();
        total_cnt++;
        if (ready_low_cnt != 0 || dma_active !== 1'b0) $display("FAIL post_reset_idle: low=%0d active=%b, want 0/0", ready_low_cnt, dma_active);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        fall_cnt      = 0;
        ready_low_cnt = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEE;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = i[7:0] ^ 8'h5A;
            mem[16'hFF00 + i] = i[7:0] ^ 8'hC3;
        end
        mem[16'h0000] = 8'h99;
        test_reset();
        test_basic();
        test_align_parity();
        test_page_ff();
        test_forced_write();
        test_passthrough();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
